outbuf_drain: RTL

- Reader for the accelerator output buffer: pops `PAR_READ`-wide groups from the output FIFO and unpacks them into a single-word valid/ready stream toward the host or DMA.
- Drains a programmed number of result words, then reports completion.
- Sits between the output buffer's `ren`/`dout`/`empty` side and the downstream consumer.

---
 rtl/outbuf_drain.sv | 139 +++++++++++++
 1 files changed

// File: rtl/outbuf_drain.sv
// Output-buffer drain: pops PAR_READ-wide groups from the result FIFO and unpacks them,
// least-significant lane first, into a one-word valid/ready stream. Optional: OUTBUF_DRAIN_RELU_EN.
module outbuf_drain #(
    parameter int DATA_WIDTH = 17,
    parameter int PAR_READ   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           out_count,
    input  logic                           buf_empty,
    input  logic [PAR_READ*DATA_WIDTH-1:0] buf_dout,
    output logic                           buf_ren,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last,
    output logic                           busy,
    output logic                           done
);

    localparam int LANE_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam logic [LANE_W-1:0]    LANE_ZERO = {LANE_W{1'b0}};
    localparam logic [LANE_W-1:0]    LANE_ONE  = {{(LANE_W-1){1'b0}}, 1'b1};
    localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(PAR_READ - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                           state_r, state_s;
    logic [PAR_READ*DATA_WIDTH-1:0]   hold_r, hold_s;
    logic [LANE_W-1:0]                lane_r, lane_s;
    logic [CNT_WIDTH-1:0]             remaining_r, remaining_s;
    logic                             ren_s;
    logic                             m_valid_r, m_last_r, busy_r, done_r;
    logic [DATA_WIDTH-1:0]            m_data_r;

    function automatic logic [DATA_WIDTH-1:0] lane_word(
        input logic [PAR_READ*DATA_WIDTH-1:0] grp,
        input logic [LANE_W-1:0]              idx
    );
        lane_word = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < PAR_READ; k++) begin
            if (idx == LANE_W'(k)) lane_word = grp[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] w);
        relu = w[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : w;
    endfunction

    // Next-state, datapath-next and pop-strobe logic
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        lane_s      = lane_r;
        remaining_s = remaining_r;
        ren_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    remaining_s = out_count;
                    if (out_count == CNT_ZERO) state_s = DONE;
                    else                       state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (!buf_empty) begin
                    ren_s   = 1'b1;
                    hold_s  = buf_dout;
                    lane_s  = LANE_ZERO;
                    state_s = SEND;
                end else begin
                    state_s = FETCH;
                end
            end
            SEND: begin
                if (m_valid_r && m_ready) begin
                    remaining_s = remaining_r - CNT_ONE;
                    lane_s      = lane_r + LANE_ONE;
                    if (remaining_r == CNT_ONE)  state_s = DONE;
                    else if (lane_r == LANE_LAST) state_s = FETCH;
                    else                          state_s = SEND;
                end else begin
                    state_s = SEND;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered-output update
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= IDLE;
            hold_r      <= {(PAR_READ*DATA_WIDTH){1'b0}};
            lane_r      <= LANE_ZERO;
            remaining_r <= CNT_ZERO;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            m_data_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            lane_r      <= lane_s;
            remaining_r <= remaining_s;
            m_valid_r   <= (state_s == SEND);
            m_last_r    <= (state_s == SEND) && (remaining_s == CNT_ONE);
            busy_r      <= (state_s == FETCH) || (state_s == SEND);
            done_r      <= (state_s == DONE);
            m_data_r    <= (state_s == SEND) ? lane_word(hold_s, lane_s) : {DATA_WIDTH{1'b0}};
        end
    end

    // Pop must follow the live empty flag; gated by reset so a reset never pops
    assign buf_ren = ren_s & rstn;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;
    assign busy    = busy_r;
    assign done    = done_r;
`ifdef OUTBUF_DRAIN_RELU_EN
    assign m_data  = relu(m_data_r);
`else
    assign m_data  = m_data_r;
`endif

endmodule
